mem_lsu: RTL and testbench

- Memory stage directly downstream of the execute core.
- Consumes the execute result (effective address for loads/stores, ALU result otherwise) plus the store data.
- Performs one data-bus transaction per load/store via valid/ready request and valid response channels; formats load data; hands a registered result to writeback over a valid/ready handshake.
- Single outstanding operation; a busy LSU back-pressures execute.

---
 rtl/mem_lsu.sv | 235 +++++++++++++++++++++++
 tb/tb_mem_lsu.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// mem_lsu: memory stage between execute and writeback.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   mem_lsu_in_*               execute operation in (valid/ready); res_data is the
//                              effective address for loads/stores, ALU result otherwise
//   mem_lsu_req_*              data-bus request (valid/ready), 8-byte aligned with strobes
//   mem_lsu_resp_*             data-bus response (read data or write ack)
//   mem_lsu_out_*              registered writeback result (valid/ready)
module mem_lsu #(
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_lsu_in_valid_i,
    output logic                  mem_lsu_in_ready_o,
    input  logic                  mem_lsu_load_i,
    input  logic                  mem_lsu_store_i,
    input  logic [1:0]            mem_lsu_size_i,
    input  logic                  mem_lsu_unsigned_i,
    input  logic [DATA_W-1:0]     mem_lsu_res_data_i,
    input  logic [DATA_W-1:0]     mem_lsu_store_data_i,
    input  logic [REG_ADDR_W-1:0] mem_lsu_rd_addr_i,
    input  logic                  mem_lsu_rd_wen_i,
    output logic                  mem_lsu_req_valid_o,
    input  logic                  mem_lsu_req_ready_i,
    output logic                  mem_lsu_req_wen_o,
    output logic [DATA_W-1:0]     mem_lsu_req_addr_o,
    output logic [DATA_W-1:0]     mem_lsu_req_wdata_o,
    output logic [7:0]            mem_lsu_req_wmask_o,
    input  logic                  mem_lsu_resp_valid_i,
    input  logic [DATA_W-1:0]     mem_lsu_resp_rdata_i,
    output logic                  mem_lsu_out_valid_o,
    input  logic                  mem_lsu_out_ready_i,
    output logic [DATA_W-1:0]     mem_lsu_out_data_o,
    output logic [REG_ADDR_W-1:0] mem_lsu_out_rd_addr_o,
    output logic                  mem_lsu_out_rd_wen_o,
    output logic                  mem_lsu_out_misalign_o
);

    localparam int unsigned NB_LANES = 8;
    localparam int unsigned OFF_W    = 3;
    localparam int unsigned SH_W     = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [DATA_W-1:0]       req_addr_q, req_addr_d;
    logic [DATA_W-1:0]       req_wdata_q, req_wdata_d;
    logic [NB_LANES-1:0]     req_wmask_q, req_wmask_d;
    logic                    req_wen_q, req_wen_d;
    logic [OFF_W-1:0]        off_q, off_d;
    logic [1:0]              size_q, size_d;
    logic                    uns_q, uns_d;
    logic [REG_ADDR_W-1:0]   op_rd_addr_q, op_rd_addr_d;
    logic                    op_rd_wen_q, op_rd_wen_d;
    logic                    out_valid_q, out_valid_d;
    logic [DATA_W-1:0]       out_data_q, out_data_d;
    logic [REG_ADDR_W-1:0]   out_rd_addr_q, out_rd_addr_d;
    logic                    out_rd_wen_q, out_rd_wen_d;
    logic                    out_misalign_q, out_misalign_d;

    logic [OFF_W-1:0]        in_off_c;
    logic                    in_is_mem_c;
    logic                    in_misalign_c;
    logic [NB_LANES-1:0]     in_mask_c;
    logic [SH_W-1:0]         in_sh_c;
    logic [SH_W-1:0]         ld_sh_c;
    logic [DATA_W-1:0]       ld_shifted_c;
    logic [DATA_W-1:0]       ld_data_c;

    assign in_off_c    = mem_lsu_res_data_i[OFF_W-1:0];
    assign in_is_mem_c = mem_lsu_load_i | mem_lsu_store_i;
    assign in_sh_c     = {in_off_c, 3'b000};

    // Alignment check and unshifted byte-strobe pattern by access size
    always_comb begin
        in_misalign_c = 1'b0;
        in_mask_c     = '0;
        case (mem_lsu_size_i)
            2'b00: begin
                in_mask_c     = 8'h01;
            end
            2'b01: begin
                in_mask_c     = 8'h03;
                in_misalign_c = in_off_c[0];
            end
            2'b10: begin
                in_mask_c     = 8'h0F;
                in_misalign_c = |in_off_c[1:0];
            end
            default: begin
                in_mask_c     = 8'hFF;
                in_misalign_c = |in_off_c;
            end
        endcase
    end

    // Load formatting: move the addressed bytes to lane 0, then extend
    assign ld_sh_c      = {off_q, 3'b000};
    assign ld_shifted_c = mem_lsu_resp_rdata_i >> ld_sh_c;

    always_comb begin
        ld_data_c = ld_shifted_c;
        case (size_q)
            2'b00:   ld_data_c = {{(DATA_W-8){ld_shifted_c[7]  & ~uns_q}}, ld_shifted_c[7:0]};
            2'b01:   ld_data_c = {{(DATA_W-16){ld_shifted_c[15] & ~uns_q}}, ld_shifted_c[15:0]};
            2'b10:   ld_data_c = {{(DATA_W-32){ld_shifted_c[31] & ~uns_q}}, ld_shifted_c[31:0]};
            default: ld_data_c = ld_shifted_c;
        endcase
    end

    // Next-state and output-register logic
    always_comb begin
        state_d            = state_q;
        req_addr_d         = req_addr_q;
        req_wdata_d        = req_wdata_q;
        req_wmask_d        = req_wmask_q;
        req_wen_d          = req_wen_q;
        off_d              = off_q;
        size_d             = size_q;
        uns_d              = uns_q;
        op_rd_addr_d       = op_rd_addr_q;
        op_rd_wen_d        = op_rd_wen_q;
        out_valid_d        = out_valid_q;
        out_data_d         = out_data_q;
        out_rd_addr_d      = out_rd_addr_q;
        out_rd_wen_d       = out_rd_wen_q;
        out_misalign_d     = out_misalign_q;
        mem_lsu_in_ready_o = 1'b0;

        // Writeback consumed the held result; a same-cycle load below overrides
        if (out_valid_q && mem_lsu_out_ready_i) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                mem_lsu_in_ready_o = !out_valid_q || mem_lsu_out_ready_i;
                if (mem_lsu_in_valid_i && mem_lsu_in_ready_o) begin
                    if (!in_is_mem_c || in_misalign_c) begin
                        // ALU pass-through, or a faulting access reported without bus traffic
                        out_valid_d    = 1'b1;
                        out_data_d     = mem_lsu_res_data_i;
                        out_rd_addr_d  = mem_lsu_rd_addr_i;
                        out_rd_wen_d   = mem_lsu_rd_wen_i && !in_is_mem_c;
                        out_misalign_d = in_is_mem_c;
                    end else begin
                        req_addr_d   = {mem_lsu_res_data_i[DATA_W-1:OFF_W], 3'b000};
                        req_wdata_d  = mem_lsu_store_data_i << in_sh_c;
                        req_wmask_d  = in_mask_c << in_off_c;
                        req_wen_d    = mem_lsu_store_i;
                        off_d        = in_off_c;
                        size_d       = mem_lsu_size_i;
                        uns_d        = mem_lsu_unsigned_i;
                        op_rd_addr_d = mem_lsu_rd_addr_i;
                        op_rd_wen_d  = mem_lsu_rd_wen_i;
                        state_d      = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (mem_lsu_req_ready_i) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (mem_lsu_resp_valid_i) begin
                    state_d        = ST_IDLE;
                    out_valid_d    = 1'b1;
                    out_data_d     = req_wen_q ? '0 : ld_data_c;
                    out_rd_addr_d  = op_rd_addr_q;
                    out_rd_wen_d   = op_rd_wen_q && !req_wen_q;
                    out_misalign_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            req_addr_q     <= '0;
            req_wdata_q    <= '0;
            req_wmask_q    <= '0;
            req_wen_q      <= 1'b0;
            off_q          <= '0;
            size_q         <= '0;
            uns_q          <= 1'b0;
            op_rd_addr_q   <= '0;
            op_rd_wen_q    <= 1'b0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            out_rd_addr_q  <= '0;
            out_rd_wen_q   <= 1'b0;
            out_misalign_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            req_addr_q     <= req_addr_d;
            req_wdata_q    <= req_wdata_d;
            req_wmask_q    <= req_wmask_d;
            req_wen_q      <= req_wen_d;
            off_q          <= off_d;
            size_q         <= size_d;
            uns_q          <= uns_d;
            op_rd_addr_q   <= op_rd_addr_d;
            op_rd_wen_q    <= op_rd_wen_d;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            out_rd_addr_q  <= out_rd_addr_d;
            out_rd_wen_q   <= out_rd_wen_d;
            out_misalign_q <= out_misalign_d;
        end
    end

    assign mem_lsu_req_valid_o    = (state_q == ST_REQ);
    assign mem_lsu_req_wen_o      = req_wen_q;
    assign mem_lsu_req_addr_o     = req_addr_q;
    assign mem_lsu_req_wdata_o    = req_wdata_q;
    assign mem_lsu_req_wmask_o    = req_wmask_q;
    assign mem_lsu_out_valid_o    = out_valid_q;
    assign mem_lsu_out_data_o     = out_data_q;
    assign mem_lsu_out_rd_addr_o  = out_rd_addr_q;
    assign mem_lsu_out_rd_wen_o   = out_rd_wen_q;
    assign mem_lsu_out_misalign_o = out_misalign_q;

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed bench for mem_lsu with an expected-result queue model
// and a per-cycle compare process on the request and writeback channels.
module tb_mem_lsu;

    localparam int unsigned DW = 64;
    localparam int unsigned RW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, ld_i, st_i, uns_i, rd_wen_i;
    logic [1:0]    size_i;
    logic [DW-1:0] res_data_i, store_data_i;
    logic [RW-1:0] rd_addr_i;
    logic          req_valid, req_ready, req_wen;
    logic [DW-1:0] req_addr, req_wdata;
    logic [7:0]    req_wmask;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;
    logic          out_valid, out_ready, out_rd_wen, out_misalign;
    logic [DW-1:0] out_data;
    logic [RW-1:0] out_rd_addr;

    always #5 clk = ~clk;

    mem_lsu #(.DATA_W(DW), .REG_ADDR_W(RW)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .mem_lsu_in_valid_i     (in_valid),
        .mem_lsu_in_ready_o     (in_ready),
        .mem_lsu_load_i         (ld_i),
        .mem_lsu_store_i        (st_i),
        .mem_lsu_size_i         (size_i),
        .mem_lsu_unsigned_i     (uns_i),
        .mem_lsu_res_data_i     (res_data_i),
        .mem_lsu_store_data_i   (store_data_i),
        .mem_lsu_rd_addr_i      (rd_addr_i),
        .mem_lsu_rd_wen_i       (rd_wen_i),
        .mem_lsu_req_valid_o    (req_valid),
        .mem_lsu_req_ready_i    (req_ready),
        .mem_lsu_req_wen_o      (req_wen),
        .mem_lsu_req_addr_o     (req_addr),
        .mem_lsu_req_wdata_o    (req_wdata),
        .mem_lsu_req_wmask_o    (req_wmask),
        .mem_lsu_resp_valid_i   (resp_valid),
        .mem_lsu_resp_rdata_i   (resp_rdata),
        .mem_lsu_out_valid_o    (out_valid),
        .mem_lsu_out_ready_i    (out_ready),
        .mem_lsu_out_data_o     (out_data),
        .mem_lsu_out_rd_addr_o  (out_rd_addr),
        .mem_lsu_out_rd_wen_o   (out_rd_wen),
        .mem_lsu_out_misalign_o (out_misalign)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [RW-1:0] rd;
        logic          wen;
        logic          mis;
        logic          chk_data;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          cur;
    logic          exp_req_act = 1'b0;
    logic [DW-1:0] exp_raddr, exp_wdata;
    logic [7:0]    exp_wmask;
    logic          exp_rwen;
    int            checks = 0;
    int            passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic m_misalign(input logic [63:0] a, input logic [1:0] sz);
        int n;
        n = 1 << sz;
        return (int'(a[2:0]) % n) != 0;
    endfunction

    function automatic logic [63:0] m_load(input logic [63:0] rdata, input logic [2:0] off,
                                           input logic [1:0] sz, input logic uns);
        int n;
        logic [63:0] v;
        n = 1 << sz;
        v = '0;
        for (int k = 0; k < n; k++) v = v | (64'(rdata[8*(int'(off)+k) +: 8]) << (8*k));
        if (!uns && n < 8 && v[8*n-1]) v = v | (64'hFFFF_FFFF_FFFF_FFFF << (8*n));
        return v;
    endfunction

    function automatic logic [7:0] m_mask(input logic [2:0] off, input logic [1:0] sz);
        logic [7:0] m;
        m = '0;
        for (int k = 0; k < (1 << sz); k++) m[int'(off)+k] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] m_wdata(input logic [63:0] sd, input logic [2:0] off);
        logic [63:0] w;
        w = '0;
        for (int i = int'(off); i < 8; i++) w[8*i +: 8] = sd[8*(i-int'(off)) +: 8];
        return w;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("stray_out_valid", 64'(out_valid), 64'd0);
                end else begin
                    cur = exp_q[0];
                    if (cur.chk_data) chk("out_data", out_data, cur.data);
                    chk("out_rd_wen", 64'(out_rd_wen), 64'(cur.wen));
                    chk("out_misalign", 64'(out_misalign), 64'(cur.mis));
                    if (cur.wen) chk("out_rd_addr", 64'(out_rd_addr), 64'(cur.rd));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (req_valid) begin
                if (!exp_req_act) begin
                    chk("stray_req_valid", 64'(req_valid), 64'd0);
                end else begin
                    chk("req_addr", req_addr, exp_raddr);
                    chk("req_wdata", req_wdata, exp_wdata);
                    chk("req_wmask", 64'(req_wmask), 64'(exp_wmask));
                    chk("req_wen", 64'(req_wen), 64'(exp_rwen));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_accept();
        int t;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Issue one operation (called at posedge+1) and play the bus side of it
    task automatic do_op(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                         input logic [63:0] addr, input logic [63:0] sdata,
                         input logic [4:0] rd, input logic wen, input logic [63:0] rdata,
                         input int req_stall, input int resp_delay);
        exp_t e;
        logic mem, mis;
        mem = ld || st;
        mis = mem && m_misalign(addr, sz);
        e.rd = rd;
        e.data = addr;
        e.chk_data = 1'b1;
        e.mis = mis;
        e.wen = wen && !mem;
        if (mem && !mis) begin
            if (st) begin
                e.chk_data = 1'b0;
                e.wen = 1'b0;
            end else begin
                e.data = m_load(rdata, addr[2:0], sz, uns);
                e.wen = wen;
            end
            exp_raddr   = {addr[63:3], 3'b000};
            exp_wdata   = m_wdata(sdata, addr[2:0]);
            exp_wmask   = m_mask(addr[2:0], sz);
            exp_rwen    = st;
            exp_req_act = 1'b1;
        end
        exp_q.push_back(e);
        in_valid = 1'b1; ld_i = ld; st_i = st; size_i = sz; uns_i = uns;
        res_data_i = addr; store_data_i = sdata; rd_addr_i = rd; rd_wen_i = wen;
        wait_accept();
        if (mem && !mis) begin
            repeat (req_stall) begin
                @(posedge clk);
                #1;
            end
            req_ready = 1'b1;
            @(posedge clk);
            #1;
            req_ready = 1'b0;
            exp_req_act = 1'b0;
            repeat (resp_delay) begin
                @(posedge clk);
                #1;
            end
            resp_valid = 1'b1;
            resp_rdata = rdata;
            @(posedge clk);
            #1;
            resp_valid = 1'b0;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_valid"}, 64'(req_valid), 64'd0);
        chk({tag, "_req_addr"}, req_addr, 64'd0);
        chk({tag, "_req_wdata"}, req_wdata, 64'd0);
        chk({tag, "_req_wmask"}, 64'(req_wmask), 64'd0);
        chk({tag, "_req_wen"}, 64'(req_wen), 64'd0);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_data"}, out_data, 64'd0);
        chk({tag, "_out_rd_addr"}, 64'(out_rd_addr), 64'd0);
        chk({tag, "_out_rd_wen"}, 64'(out_rd_wen), 64'd0);
        chk({tag, "_out_misalign"}, 64'(out_misalign), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] alu_vals[3];
        logic [63:0] tb_addr[7];
        logic [1:0]  tb_size[7];
        logic        tb_ld[7];
        logic        tb_uns[7];
        logic [63:0] mem_word;
        int t;

        alu_vals = '{64'h11, 64'h22, 64'h33};
        rst_n = 1'b0;
        in_valid = 0; ld_i = 0; st_i = 0; size_i = 0; uns_i = 0; rd_wen_i = 0;
        res_data_i = '0; store_data_i = '0; rd_addr_i = '0;
        req_ready = 0; resp_valid = 0; resp_rdata = '0; out_ready = 1'b1;

        // Model pins
        chk("model_lb", m_load(64'h0000_0000_8000_0000, 3'd3, 2'b00, 1'b0), 64'hFFFF_FFFF_FFFF_FF80);
        chk("model_lhu", m_load(64'hBEEF_0000_0000_0000, 3'd6, 2'b01, 1'b1), 64'h0000_0000_0000_BEEF);
        chk("model_sw_mask", 64'(m_mask(3'd4, 2'b10)), 64'hF0);

        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset while waiting for a response; a late response must be ignored
        in_valid = 1'b1; ld_i = 1'b1; st_i = 1'b0; size_i = 2'b00; uns_i = 1'b0;
        res_data_i = 64'h1003; rd_addr_i = 5'd3; rd_wen_i = 1'b1;
        exp_raddr = 64'h1000; exp_wdata = '0; exp_wmask = 8'h08; exp_rwen = 1'b0; exp_req_act = 1'b1;
        wait_accept();
        req_ready = 1'b1;
        @(posedge clk);
        #1;
        req_ready = 1'b0;
        exp_req_act = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        resp_valid = 1'b1;
        resp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk);
        #1;
        resp_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stray_resp_out_valid", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;

        // Signed byte load after the reset
        do_op(1'b1, 1'b0, 2'b00, 1'b0, 64'h1003, 64'h0, 5'd5, 1'b1, 64'h0000_0000_8000_0000, 0, 0);
        chk("lb_data", out_data, 64'hFFFF_FFFF_FFFF_FF80);
        chk("lb_rd_wen", 64'(out_rd_wen), 64'd1);
        chk("lb_req_addr", req_addr, 64'h1000);
        @(posedge clk);
        #1;

        // ALU back-to-back at full throughput
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{data: alu_vals[i], rd: 5'(i + 1), wen: 1'b1, mis: 1'b0, chk_data: 1'b1});
            in_valid = 1'b1; ld_i = 0; st_i = 0; size_i = 2'b11; uns_i = 0;
            res_data_i = alu_vals[i]; rd_addr_i = 5'(i + 1); rd_wen_i = 1'b1;
            @(negedge clk);
            chk("alu_in_ready", 64'(in_ready), 64'd1);
            if (i > 0) chk("alu_b2b_data", out_data, alu_vals[i-1]);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("alu_b2b_last", out_data, 64'h33);
        @(posedge clk);
        #1;

        // Unsigned half load with request stalls
        do_op(1'b1, 1'b0, 2'b01, 1'b1, 64'h2006, 64'h0, 5'd9, 1'b1, 64'hBEEF_0000_0000_0000, 2, 1);
        chk("lhu_data", out_data, 64'h0000_0000_0000_BEEF);
        @(posedge clk);
        #1;

        // Word store
        do_op(1'b0, 1'b1, 2'b10, 1'b0, 64'h3004, 64'h1234_5678, 5'd4, 1'b1, 64'h0, 0, 0);
        chk("sw_wmask", 64'(req_wmask), 64'hF0);
        chk("sw_wdata", req_wdata, 64'h1234_5678_0000_0000);
        chk("sw_wen", 64'(req_wen), 64'd1);
        chk("sw_out_rd_wen", 64'(out_rd_wen), 64'd0);
        chk("sw_out_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;

        // Misaligned word load with writeback back-pressure
        out_ready = 1'b0;
        do_op(1'b1, 1'b0, 2'b10, 1'b0, 64'h4002, 64'h0, 5'd7, 1'b1, 64'h0, 0, 0);
        repeat (3) begin
            @(negedge clk);
            chk("mis_out_valid", 64'(out_valid), 64'd1);
            chk("mis_flag", 64'(out_misalign), 64'd1);
            chk("mis_data", out_data, 64'h4002);
            chk("mis_in_ready", 64'(in_ready), 64'd0);
            chk("mis_no_req", 64'(req_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("mis_in_ready_release", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Mixed table of loads, stores and faults over one memory word
        mem_word = 64'hF1E2_D3C4_B5A6_9788;
        tb_addr = '{64'h5000, 64'h5004, 64'h5002, 64'h5007, 64'h6005, 64'h6003, 64'h6008};
        tb_size = '{2'b11, 2'b10, 2'b01, 2'b00, 2'b00, 2'b01, 2'b11};
        tb_ld   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tb_uns  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            do_op(tb_ld[i], !tb_ld[i], tb_size[i], tb_uns[i], tb_addr[i], 64'hCAFE_0000_0000_00AB + 64'(i),
                  5'(10 + i), 1'b1, mem_word, i % 2, i % 3);
        end

        t = 0;
        while (exp_q.size() != 0 && t < 20) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
